// File: rtl/lc3b_types_pkg.sv
// rtl/lc3b_types_pkg.sv - shared LC-3b word/line types and eviction buffer state encoding
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } ewb_state_t;

endpackage

// File: rtl/ewb_ctrl_n_entry_array.sv
// rtl/ewb_ctrl_n_entry_array.sv - circular line store with youngest-match address CAM
module ewb_entry_array #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [LINE_W-1:0]          push_line,
    input  logic                       pop,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [LINE_W-1:0]          wr_line,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   hit_idx,
    output logic [LINE_W-1:0]          hit_line,
    output logic [$clog2(DEPTH)-1:0]   head_idx,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [LINE_W-1:0]          head_line,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] line_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     scan_idx;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            if (pop_ok) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[tail_q] <= push_addr;
            line_q[tail_q] <= push_line;
        end
        if (wr_en) begin
            line_q[wr_idx] <= wr_line;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = head_q;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (valid_q[scan_idx] && (addr_q[scan_idx] == lookup_addr)) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    assign hit_line  = line_q[hit_idx];
    assign head_idx  = head_q;
    assign head_addr = addr_q[head_q];
    assign head_line = line_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/ewb_ctrl_n.sv
// rtl/ewb_ctrl_n.sv - multi-entry eviction/write buffer between L1 and the L2/memory port
module ewb_ctrl_n
    import lc3b_types::*;
#(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = $bits(lc3b_word),
    parameter int LINE_W       = $bits(lc3b_line),
    parameter int DRAIN_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     orig_strobe,
    input  logic                     orig_write,
    input  logic [ADDR_W-1:0]        orig_addr,
    input  logic [LINE_W-1:0]        orig_wdata,
    output logic [LINE_W-1:0]        orig_rdata,
    output logic                     orig_resp,
    output logic                     dest_strobe,
    output logic                     dest_write,
    output logic [ADDR_W-1:0]        dest_addr,
    output logic [LINE_W-1:0]        dest_wdata,
    input  logic [LINE_W-1:0]        dest_rdata,
    input  logic                     dest_resp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH = CW'(DRAIN_THRESH);

    ewb_state_t        state_q;
    ewb_state_t        state_d;
    logic              hit;
    logic [PW-1:0]     hit_idx;
    logic [LINE_W-1:0] hit_line;
    logic [PW-1:0]     head_idx;
    logic [ADDR_W-1:0] head_addr;
    logic [LINE_W-1:0] head_line;
    logic              wr_req;
    logic              rd_req;
    logic              draining;
    logic              coalesce;
    logic              push;
    logic              pop;

    assign wr_req   = orig_strobe && orig_write && (state_q != READ);
    assign rd_req   = orig_strobe && !orig_write;
    assign draining = (state_q == WRITE);
    // The head line is on the bus while draining, so it must not change under it.
    assign coalesce = wr_req && hit && !(draining && (hit_idx == head_idx));
    assign push     = wr_req && !coalesce && !full;
    assign pop      = draining && dest_resp;

    ewb_entry_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_entries (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (orig_addr),
        .push_line   (orig_wdata),
        .pop         (pop),
        .wr_en       (coalesce),
        .wr_idx      (hit_idx),
        .wr_line     (orig_wdata),
        .lookup_addr (orig_addr),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .hit_line    (hit_line),
        .head_idx    (head_idx),
        .head_addr   (head_addr),
        .head_line   (head_line),
        .count       (count),
        .full        (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_strobe = 1'b0;
        dest_write  = 1'b0;
        dest_addr   = '0;
        dest_wdata  = '0;
        orig_resp   = 1'b0;
        orig_rdata  = '0;

        if (wr_req) begin
            orig_resp = coalesce || !full;
        end else if (rd_req && hit && (state_q != READ)) begin
            orig_resp  = 1'b1;
            orig_rdata = hit_line;
        end

        case (state_q)
            IDLE: begin
                if (rd_req && !hit) begin
                    state_d = READ;
                end else if ((count >= THRESH) || ((count != '0) && !orig_strobe)) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                dest_strobe = 1'b1;
                dest_addr   = orig_addr;
                orig_resp   = dest_resp;
                orig_rdata  = dest_rdata;
                if (dest_resp) begin
                    state_d = GAP;
                end
            end
            WRITE: begin
                dest_strobe = 1'b1;
                dest_write  = 1'b1;
                dest_addr   = head_addr;
                dest_wdata  = head_line;
                if (dest_resp) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ewb_ctrl_n.sv
// tb/tb_ewb_ctrl_n.sv - directed self-checking bench for ewb_ctrl_n
module tb_ewb_ctrl_n;

    logic         clk;
    logic         rst_n;
    logic         orig_strobe;
    logic         orig_write;
    logic [15:0]  orig_addr;
    logic [127:0] orig_wdata;
    logic [127:0] orig_rdata;
    logic         orig_resp;
    logic         dest_strobe;
    logic         dest_write;
    logic [15:0]  dest_addr;
    logic [127:0] dest_wdata;
    logic [127:0] dest_rdata;
    logic         dest_resp;
    logic [2:0]   count;
    logic         full;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;

    logic [15:0]  wq_a [$];
    logic [127:0] wq_d [$];
    logic [15:0]  rq_a [$];

    ewb_ctrl_n #(
        .DEPTH        (4),
        .ADDR_W       (16),
        .LINE_W       (128),
        .DRAIN_THRESH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .orig_strobe (orig_strobe),
        .orig_write  (orig_write),
        .orig_addr   (orig_addr),
        .orig_wdata  (orig_wdata),
        .orig_rdata  (orig_rdata),
        .orig_resp   (orig_resp),
        .dest_strobe (dest_strobe),
        .dest_write  (dest_write),
        .dest_addr   (dest_addr),
        .dest_wdata  (dest_wdata),
        .dest_rdata  (dest_rdata),
        .dest_resp   (dest_resp),
        .count       (count),
        .full        (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] mk(input logic [15:0] k);
        return {8{k ^ 16'h5A00}};
    endfunction

    function automatic logic [127:0] rd_pat(input logic [15:0] a);
        return {8{a}};
    endfunction

    // Downstream memory model: answers every access on its third cycle.
    initial begin
        int wcnt;
        wcnt       = 0;
        dest_resp  = 1'b0;
        dest_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (dest_resp) begin
                dest_resp  = 1'b0;
                dest_rdata = '0;
                wcnt       = 0;
            end else if (dest_strobe) begin
                if (wcnt == 2) begin
                    dest_resp = 1'b1;
                    if (dest_write) begin
                        wq_a.push_back(dest_addr);
                        wq_d.push_back(dest_wdata);
                    end else begin
                        rq_a.push_back(dest_addr);
                        dest_rdata = rd_pat(dest_addr);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (dest_strobe) strobe_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        orig_strobe = 1'b0;
        orig_write  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns at posedge+1; holds the request until orig_resp.
    task automatic up_req(input string tag, input logic w, input logic [15:0] a,
                          input logic [127:0] d, output logic [127:0] rd, output int waits);
        orig_strobe = 1'b1;
        orig_write  = w;
        orig_addr   = a;
        orig_wdata  = d;
        waits       = 0;
        @(negedge clk);
        while (!orig_resp && waits < 200) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            waits++;
        end
        rd = orig_rdata;
        if (!orig_resp) check_eq({tag, "_timeout"}, orig_resp, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        orig_strobe = 1'b0;
        while (count != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, count, 0);
        idle(2);
    endtask

    task automatic exp_wr(input string tag, input logic [15:0] a, input logic [127:0] d);
        logic [15:0]  ga;
        logic [127:0] gd;
        ga = '1;
        gd = '0;
        if (wq_a.size() > 0) begin
            ga = wq_a.pop_front();
            gd = wq_d.pop_front();
        end
        check_eq({tag, "_addr"}, ga, a);
        check_eq({tag, "_data"}, gd, d);
    endtask

    initial begin
        logic [127:0] rd;
        int           waits;
        int           s0;
        logic [15:0]  a;

        rst_n       = 1'b0;
        orig_strobe = 1'b0;
        orig_write  = 1'b0;
        orig_addr   = '0;
        orig_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_dest_strobe", dest_strobe, 0);
        check_eq("rst_orig_resp", orig_resp, 0);
        rst_n = 1'b1;
        idle(2);

        // Coalesce: two writes to one line keep one entry, read returns the newer line
        s0 = strobe_cnt;
        up_req("co_w1", 1'b1, 16'h0040, mk(16'h0001), rd, waits);
        up_req("co_w2", 1'b1, 16'h0040, mk(16'h0002), rd, waits);
        check_eq("co_count", count, 1);
        check_eq("co_w2_waits", waits, 0);
        up_req("co_rd", 1'b0, 16'h0040, '0, rd, waits);
        check_eq("co_rd_data", rd, mk(16'h0002));
        check_eq("co_rd_waits", waits, 0);
        check_eq("co_no_strobe", strobe_cnt - s0, 0);
        wait_empty("co_drain");
        exp_wr("co_wr", 16'h0040, mk(16'h0002));
        check_eq("co_one_write", wq_a.size(), 0);

        // Fill to full, fifth write stalls until the first drain completes
        for (int i = 1; i <= 4; i++) begin
            a = 16'(i * 16);
            up_req("fill_w", 1'b1, a, mk(a), rd, waits);
        end
        check_eq("fill_count", count, 4);
        check_eq("fill_full", full, 1);
        up_req("fill_w5", 1'b1, 16'h0050, mk(16'h0050), rd, waits);
        check_eq("fill_w5_stalled", waits > 0, 1);
        check_eq("fill_w5_after_one_drain", wq_a.size(), 1);
        check_eq("fill_count_after_w5", count, 4);
        wait_empty("fill_drain");
        for (int i = 1; i <= 5; i++) begin
            a = 16'(i * 16);
            exp_wr("fill_order", a, mk(a));
        end

        // Write to the draining head address allocates a fresh entry
        up_req("hd_w1", 1'b1, 16'h0010, mk(16'h0A0A), rd, waits);
        idle(1);
        check_eq("hd_in_write", dest_write, 1);
        up_req("hd_w2", 1'b1, 16'h0010, mk(16'h0B0B), rd, waits);
        check_eq("hd_w2_waits", waits, 0);
        check_eq("hd_count", count, 2);
        up_req("hd_rd", 1'b0, 16'h0010, '0, rd, waits);
        check_eq("hd_rd_data", rd, mk(16'h0B0B));
        check_eq("hd_rd_waits", waits, 0);
        wait_empty("hd_drain");
        exp_wr("hd_first", 16'h0010, mk(16'h0A0A));
        exp_wr("hd_second", 16'h0010, mk(16'h0B0B));

        // Read miss arriving during WRITE waits for GAP/IDLE then goes downstream
        up_req("rm_w", 1'b1, 16'h0020, mk(16'h0C0C), rd, waits);
        idle(1);
        check_eq("rm_in_write", dest_write, 1);
        up_req("rm_rd", 1'b0, 16'h0080, '0, rd, waits);
        check_eq("rm_rd_data", rd, rd_pat(16'h0080));
        check_eq("rm_waited", waits > 3, 1);
        check_eq("rm_rd_addr", (rq_a.size() > 0) ? rq_a.pop_front() : 16'hFFFF, 16'h0080);
        exp_wr("rm_write_first", 16'h0020, mk(16'h0C0C));
        idle(2);

        // Pointer wrap: pairs of writes then drain, eight lines in total
        for (int r = 0; r < 4; r++) begin
            a = 16'(16'h0100 + 2 * r);
            up_req("wr_w0", 1'b1, a, mk(a), rd, waits);
            check_eq("wrap_count1", count, 1);
            up_req("wr_w1", 1'b1, a + 16'd1, mk(a + 16'd1), rd, waits);
            check_eq("wrap_count2", count, 2);
            wait_empty("wrap_drain");
        end
        for (int i = 0; i < 8; i++) begin
            a = 16'(16'h0100 + i);
            exp_wr("wrap_order", a, mk(a));
        end
        check_eq("wrap_no_extra", wq_a.size(), 0);

        // Asynchronous reset in the middle of a drain
        up_req("ar_w", 1'b1, 16'h0040, mk(16'h0E0E), rd, waits);
        idle(1);
        check_eq("ar_strobe_before", dest_strobe, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_strobe_dropped", dest_strobe, 0);
        check_eq("ar_count", count, 0);
        check_eq("ar_full", full, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        up_req("ar_rd", 1'b0, 16'h0040, '0, rd, waits);
        check_eq("ar_rd_data", rd, rd_pat(16'h0040));
        check_eq("ar_rd_addr", (rq_a.size() > 0) ? rq_a.pop_front() : 16'hFFFF, 16'h0040);
        check_eq("ar_no_write", wq_a.size(), 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ewb_ctrl_n.md
Name: ewb_ctrl_n

Overview:
Parametrised multi-entry eviction/write buffer between the L1 cache and the L2/physical memory port. It replaces the single-entry buffer. Features:
- Absorbs up to DEPTH dirty-line writebacks.
- Coalesces repeat writes to the same line address.
- Serves read hits from buffered lines.
- Drains to the downstream port in FIFO order, under a selectable drain policy.

Parameters:
DEPTH, 4, number of line entries (power of two, 2..16)
ADDR_W, 16, line address width (lc3b_word)
LINE_W, 128, cache line width (lc3b_line)
DRAIN_THRESH, 1, occupancy at or above which draining starts even while upstream is busy (1..DEPTH)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
orig_strobe  in  1  upstream request valid
orig_write  in  1  1=writeback, 0=read
orig_addr  in  ADDR_W  upstream line address
orig_wdata  in  LINE_W  writeback line
orig_rdata  out  LINE_W  read data to upstream
orig_resp  out  1  upstream request complete (one cycle per request)
dest_strobe  out  1  downstream request valid
dest_write  out  1  downstream write
dest_addr  out  ADDR_W  downstream address
dest_wdata  out  LINE_W  downstream write line
dest_rdata  in  LINE_W  downstream read data
dest_resp  in  1  downstream complete
count  out  $clog2(DEPTH)+1  valid entries
full  out  1  count==DEPTH

Behaviour:
- Reset (async assert, sync release): all entries invalid, head=tail=0, state IDLE. All outputs 0.
- Reset mid-transaction abandons the downstream access. The buffered data is lost by design.
- Storage: circular FIFO of {valid, addr, line}. head is the oldest entry; pop at head; push at tail; pointers wrap modulo DEPTH.
- Match: compare orig_addr against all valid entries. If more than one entry matches, the youngest wins.
- Upstream write:
  - Match on an entry that is not being drained: overwrite its line in place (coalesce). No allocation; orig_resp=1 in the same cycle.
  - Otherwise, if not full at cycle start: push at tail, orig_resp=1 in the same cycle.
  - If full with no coalescible match: orig_resp=0 and the request stalls. Upstream holds the request; a push and a pop in the same cycle are not bypassed.
- Upstream read hit: orig_rdata = matching line, orig_resp=1 combinationally. Served in every state.
- Upstream read miss:
  - Handled only from IDLE: go to READ, drive dest_strobe=1, dest_write=0, dest_addr=orig_addr.
  - While in READ, orig_resp=dest_resp and orig_rdata=dest_rdata.
  - On dest_resp, go to GAP.
  - A miss that arrives in WRITE or GAP waits.
- States:
  - IDLE: a pending read miss takes priority and goes to READ. Otherwise go to WRITE if count>=DRAIN_THRESH, or if count>0 and orig_strobe=0.
  - READ: as above.
  - WRITE: dest_strobe=1, dest_write=1, dest_addr/dest_wdata = head entry, held stable until dest_resp. On dest_resp, pop head (count-1) and go to GAP.
  - GAP: one cycle with dest_strobe=0 so the downstream resp can deassert. Always returns to IDLE.
- The draining head entry is excluded from coalescing. A write to that address allocates a new entry; read hits still take the youngest entry.
- In WRITE, a push and a dest_resp pop in the same cycle leave count unchanged.
- Upstream writes and read hits continue during WRITE and GAP.
- count never exceeds DEPTH and never underflows. Pointer wrap must be exact at DEPTH-1 → 0.

Decomposition:
- lc3b_types package: lc3b_word and lc3b_line (existing), plus new enum ewb_state_t {IDLE, READ, WRITE, GAP}.
- Sub-module ewb_entry_array: entry storage, valid bits, head/tail/count, youngest-match CAM. Its outputs are hit, hit_idx, hit_line, and head_{addr,line}.
- ewb_ctrl_n contains the FSM and port muxing.

Test Plan:
- Reset with rst_n=0 mid-WRITE → dest_strobe drops asynchronously; count=0; full=0; next read of 0x0040 goes downstream.
- Write 0x0040, then write 0x0040 again with new data, DEPTH=4, DRAIN_THRESH=4 → count=1; read of 0x0040 returns the second line with orig_resp in the same cycle; no dest_strobe.
- Four writes to 0x0010/20/30/40, then a fifth write to 0x0050 → full=1; fifth stalls until the first dest_resp. Drain order is 0x0010,20,30,40; then 0x0050 is accepted.
- Hold a write to 0x0010 while the 0x0010 entry is draining (WRITE) → new entry allocated; a subsequent read of 0x0010 returns the new line; two downstream writes to 0x0010 in order.
- Issue a read miss of 0x0080 while in WRITE → waits through GAP; dest_write=0 read issued from IDLE; orig_rdata=dest_rdata with orig_resp on dest_resp.
- Eight writes plus drains around the pointer wrap → correct FIFO order and count at each step; no lost or duplicated line.
